gf8_mac_stream: RTL and testbench

- Streaming GF(2^8) multiply-accumulate stage. Accepts operand pairs over a valid/ready handshake and multiplies each pair in GF(2^8).
- XOR-accumulates the products across a frame delimited by in_last, then presents the frame sum on a valid/ready output.
- Sits directly downstream of the combinational field multiplier. It is the consumer that turns per-byte products into dot products, as used by MixColumns and syndrome computation.

---
 rtl/gf8_pkg.sv | 22 ++
 rtl/gf8_mul_comb.sv | 25 ++
 rtl/gf8_mac_stream.sv | 123 ++++++++++++
 tb/tb_gf8_mac_stream.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf8_pkg.sv
// Shared GF(2^8) definitions: the AES field polynomial, the MAC stage states
// and the modular reduction of a 15-bit carry-less product.
package gf8_pkg;

    localparam logic [7:0] GF8_POLY_AES = 8'h1B;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Clears bits 14..8 from the top down; x^8 is the implicit leading term of poly.
    function automatic logic [7:0] gf8_reduce(input logic [14:0] x, input logic [7:0] poly);
        logic [14:0] r;
        r = x;
        for (int i = 14; i >= 8; i--) begin
            if (r[i]) r = r ^ ({6'b0, 1'b1, poly} << (i - 8));
        end
        return r[7:0];
    endfunction

endpackage

// File: rtl/gf8_mul_comb.sv
// Combinational GF(2^8) multiplier: carry-less product followed by reduction
// modulo {1, POLY}.
import gf8_pkg::*;

module gf8_mul_comb #(
    parameter logic [7:0] POLY = GF8_POLY_AES
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    logic [14:0] prod;

    // NOTE: every variable written in always_comb is given a value first, so no latch can form.
    always_comb begin
        prod = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) prod = prod ^ ({7'b0, a} << i);
        end
    end

    assign p = gf8_reduce(prod, POLY);

endmodule

// File: rtl/gf8_mac_stream.sv
// Streaming GF(2^8) multiply-accumulate: XOR-sums operand products over a frame
// and presents the sum on a valid/ready output. Define GF8_MAC_PIPE_EN to add a
// register stage between the multiplier and the accumulator.
import gf8_pkg::*;

module gf8_mac_stream #(
    parameter logic [7:0] POLY    = GF8_POLY_AES,
    parameter int         MAX_LEN = 255,
    parameter int         CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    state_t             state, state_next;
    logic [7:0]         p;
    logic [7:0]         acc;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic               cnt_max;
    logic               ovf;
    logic               accept;
    logic               beat_vld;
    logic               beat_last;
    logic [7:0]         beat_p;
    logic               stall;

    gf8_mul_comb #(.POLY(POLY)) u_mul (
        .a (in_a),
        .b (in_b),
        .p (p)
    );

    assign accept = in_valid && in_ready;

`ifdef GF8_MAC_PIPE_EN
    logic [7:0] p_q;
    logic       last_q;
    logic       vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q    <= '0;
            last_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            p_q    <= p;
            last_q <= in_last && accept;
            vld_q  <= accept;
        end
    end

    assign beat_vld  = vld_q;
    assign beat_p    = p_q;
    assign beat_last = last_q;
    // Close the input while the frame's last beat is still in the stage register.
    assign stall     = vld_q && last_q;
`else
    assign beat_vld  = accept;
    assign beat_p    = p;
    assign beat_last = in_last;
    assign stall     = 1'b0;
`endif

    assign in_ready  = (state == ACC) && !stall;
    assign out_valid = (state == HOLD);

    assign cnt_max = (cnt == CNT_W'(MAX_LEN));
    assign cnt_inc = cnt_max ? cnt : cnt + CNT_W'(1);

    always_comb begin
        state_next = state;
        case (state)
            ACC:     if (beat_vld && beat_last) state_next = HOLD;
            HOLD:    if (out_ready)             state_next = ACC;
            default: state_next = ACC;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (beat_vld) begin
            if (beat_last) begin
                out_data  <= acc ^ beat_p;
                out_count <= cnt_inc;
                out_ovf   <= ovf | cnt_max;
                acc       <= '0;
                cnt       <= '0;
                ovf       <= 1'b0;
            end else begin
                acc <= acc ^ beat_p;
                cnt <= cnt_inc;
                ovf <= ovf | cnt_max;
            end
        end
    end

endmodule

// File: tb/tb_gf8_mac_stream.sv
// Randomized and directed bench for gf8_mac_stream against a shift-and-add
// GF(2^8) reference model; honours GF8_MAC_PIPE_EN for latency expectations.
module tb_gf8_mac_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [7:0] out_count;
    logic       out_ovf;

    int checks = 0;
    int errors = 0;

`ifdef GF8_MAC_PIPE_EN
    localparam int EXP_LAT = 2;
`else
    localparam int EXP_LAT = 1;
`endif

    gf8_mac_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    // Russian-peasant multiply in the AES field.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        while (y != 0) begin
            if (y[0]) r = r ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
            y = y >> 1;
        end
        return r;
    endfunction

    task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic last);
        bit ok = 0;
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                ok = 1;
                break;
            end
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_beat timeout: in_ready stayed 0, required 1");
        end
    endtask

    task automatic get_result(output logic [7:0] d, output logic [7:0] c, output logic o,
                              output int lat);
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL get_result timeout: out_valid=%0b required 1", out_valid);
        end
        d = out_data; c = out_count; o = out_ovf;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic expect_result(input string name, input logic [7:0] ed, input logic [7:0] ec,
                                 input logic eo);
        logic [7:0] d, c;
        logic       o;
        int         lat;
        get_result(d, c, o, lat);
        checks++;
        if ({o, c, d} !== {eo, ec, ed}) begin
            errors++;
            $display("FAIL %s: data=%h count=%0d ovf=%0b required data=%h count=%0d ovf=%0b",
                     name, d, c, o, ed, ec, eo);
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({in_ready, out_valid, out_data, out_count, out_ovf} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset: in_ready=%0b out_valid=%0b data=%h count=%0d ovf=%0b required 1 0 00 0 0",
                     in_ready, out_valid, out_data, out_count, out_ovf);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_beat;
        logic [7:0] d, c;
        logic       o;
        int         lat;
        send_beat(8'h02, 8'h87, 1'b1);
        get_result(d, c, o, lat);
        checks++;
        if ({o, c, d} !== {1'b0, 8'd1, 8'h15}) begin
            errors++;
            $display("FAIL single_beat: data=%h count=%0d ovf=%0b required data=15 count=1 ovf=0", d, c, o);
        end
        checks++;
        if (lat != EXP_LAT) begin
            errors++;
            $display("FAIL single_beat latency: got %0d required %0d", lat, EXP_LAT);
        end
    endtask

    task automatic test_back_to_back;
        send_beat(8'h57, 8'h83, 1'b0);
        send_beat(8'h57, 8'h13, 1'b1);
        expect_result("frame_57", 8'h3F, 8'd2, 1'b0);
        send_beat(8'h00, 8'hFF, 1'b1);
        expect_result("zero_operand", 8'h00, 8'd1, 1'b0);
    endtask

    task automatic test_backpressure;
        int waited = 0;
        send_beat(8'h57, 8'h83, 1'b0);
        send_beat(8'h57, 8'h13, 1'b1);
        while (!out_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        in_a = 8'h01; in_b = 8'h01; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, out_data, out_count} !== {1'b1, 1'b0, 8'h3F, 8'd2}) begin
                errors++;
                $display("FAIL hold_stable cyc%0d: out_valid=%0b in_ready=%0b data=%h count=%0d required 1 0 3f 2",
                         i, out_valid, in_ready, out_data, out_count);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, out_data} !== {1'b0, 1'b1, 8'h3F}) begin
            errors++;
            $display("FAIL hold_exit: out_valid=%0b in_ready=%0b data=%h required 0 1 3f",
                     out_valid, in_ready, out_data);
        end
        @(posedge clk);
        #1;
        send_beat(8'h02, 8'h87, 1'b1);
        expect_result("after_hold", 8'h15, 8'd1, 1'b0);
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 257; i++) send_beat(8'h01, 8'h01, (i == 257));
        expect_result("overflow", 8'h01, 8'd255, 1'b1);
        send_beat(8'h01, 8'h01, 1'b1);
        expect_result("post_overflow", 8'h01, 8'd1, 1'b0);
    endtask

    task automatic test_reset_mid_frame;
        send_beat(8'h57, 8'h83, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_frame out_valid: got %0b required 0", out_valid);
        end
        rst_n = 1'b1;
        send_beat(8'h02, 8'h87, 1'b1);
        expect_result("reset_mid_frame", 8'h15, 8'd1, 1'b0);
    endtask

    task automatic test_random;
        logic [16:0] exp_q[$];
        int          seen = 0;
        fork
            begin : driver
                for (int f = 0; f < 1000; f++) begin
                    int         len = $urandom_range(1, 20);
                    logic [7:0] av[20];
                    logic [7:0] bv[20];
                    logic [7:0] sum = 8'h00;
                    for (int k = 0; k < len; k++) begin
                        av[k] = 8'($urandom);
                        bv[k] = 8'($urandom);
                        sum   = sum ^ ref_mul(av[k], bv[k]);
                    end
                    exp_q.push_back({1'b0, 8'(len), sum});
                    for (int k = 0; k < len; k++) begin
                        int gap = $urandom_range(0, 1);
                        if (gap > 0) begin
                            repeat (gap) @(posedge clk);
                            #1;
                        end
                        send_beat(av[k], bv[k], (k == len - 1));
                    end
                end
            end
            begin : consumer
                for (int cyc = 0; cyc < 60000 && seen < 1000; cyc++) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        logic [16:0] e;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL random unexpected result: data=%h count=%0d", out_data, out_count);
                        end else begin
                            e = exp_q.pop_front();
                            if ({out_ovf, out_count, out_data} !== e) begin
                                errors++;
                                $display("FAIL random frame %0d: data=%h count=%0d ovf=%0b required data=%h count=%0d ovf=%0b",
                                         seen, out_data, out_count, out_ovf, e[7:0], e[15:8], e[16]);
                            end
                        end
                        seen++;
                    end
                end
                out_ready = 1'b0;
            end
        join
        checks++;
        if (seen != 1000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random completion: results seen %0d pending %0d required 1000 and 0",
                     seen, exp_q.size());
        end
    endtask

    initial begin
        test_reset;
        test_single_beat;
        test_back_to_back;
        test_backpressure;
        test_overflow;
        test_reset_mid_frame;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
